// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM states and the buffered
// {pc, instr} entry.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_if.sv
// Valid/ready bus from the fetch buffer head to decode.
interface fetch_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry fetch buffer with push/pop/flush; the head reads as zero while empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             rd_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign rd_entry = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC register, IDLE/FETCH/HALT FSM and fetch buffer toward decode.
// Optional FETCH_PERF_EN adds saturating push and stall counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] END_ADDR = 32'h0000_0080,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   pc,
  input  logic [31:0]   instr_in,
  fetch_if.master       dec,
`ifdef FETCH_PERF_EN
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_stalls,
`endif
  output logic          busy,
  output logic          halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          pop, push, flush, stall;
  logic          redirect_take, start_take;
  logic [CW-1:0] count;
  fetch_entry_t  head, tail;

  assign tail = {pc_q, instr_in};

  // Redirect outranks start, which outranks normal fetch/halt progress.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    push          = 1'b0;
    flush         = 1'b0;
    stall         = 1'b0;
    pop           = dec.out_valid & dec.out_ready;
    redirect_take = redirect_valid && (state_q != IDLE);
    start_take    = start && !redirect_take;
    if (redirect_take) begin
      flush   = 1'b1;
      state_d = FETCH;
      pc_d    = redirect_pc & ~32'd3;
    end else if (start_take) begin
      flush   = (state_q == FETCH);
      state_d = FETCH;
      pc_d    = RESET_PC;
    end else if (state_q == FETCH) begin
      if (pc_q >= END_ADDR) begin
        state_d = HALT;
      end else if ((count != CW'(DEPTH)) || pop) begin
        push = 1'b1;
        pc_d = pc_q + INSTR_BYTES;
      end else begin
        stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (tail),
    .rd_entry (head),
    .count    (count)
  );

  assign pc            = pc_q;
  assign dec.out_valid = (count != '0);
  assign dec.out_instr = head.instr;
  assign dec.out_pc    = head.pc;
  assign busy          = (state_q == FETCH) || (count != '0);
  assign halted        = (state_q == HALT) && (count == '0);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stalls_d  = perf_stalls_q;
    if (start_take) begin
      perf_fetched_d = '0;
      perf_stalls_d  = '0;
    end else begin
      if (push && (perf_fetched_q != 32'hFFFF_FFFF)) perf_fetched_d = perf_fetched_q + 32'd1;
      if (stall && (perf_stalls_q != 32'hFFFF_FFFF)) perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random stimulus against a queue-based
// reference model. Perf counters are checked when FETCH_PERF_EN is defined.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] END_ADDR = 32'h0000_0080;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc;
  logic [31:0] instr_in;
  logic        busy, halted;
  logic [31:0] imem [32];
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stalls;
`endif

  fetch_if dbus ();

  always #5 clk = ~clk;

  assign instr_in = (pc < END_ADDR) ? imem[pc[6:2]] : 32'h0;

  fetch_ctrl #(.RESET_PC(RESET_PC), .END_ADDR(END_ADDR), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .instr_in       (instr_in),
    .dec            (dbus),
`ifdef FETCH_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_stalls    (perf_stalls),
`endif
    .busy           (busy),
    .halted         (halted)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: a queue of fetched words plus the fetch mode and PC.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  int          mode;        // 0 idle, 1 fetching, 2 halted
  logic [31:0] m_pc;
  logic [31:0] m_fetched, m_stalls;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    q.delete();
    mode      = 0;
    m_pc      = RESET_PC;
    m_fetched = '0;
    m_stalls  = '0;
  endtask

  task automatic model_update(input logic s, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit do_pop;
    bit do_push;
    do_pop  = (q.size() > 0) && rdy;
    do_push = 1'b0;
    if (rv && mode != 0) begin
      q.delete();
      m_pc = rpc & ~32'd3;
      mode = 1;
    end else if (s) begin
      if (mode == 1) q.delete();
      m_pc      = RESET_PC;
      mode      = 1;
      m_fetched = '0;
      m_stalls  = '0;
    end else begin
      if (mode == 1) begin
        if (m_pc >= END_ADDR)                          mode = 2;
        else if (q.size() - int'(do_pop) < DEPTH)      do_push = 1'b1;
        else                                           m_stalls = sat_inc(m_stalls);
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{pc: m_pc, instr: 32'hA000_0000 | m_pc});
        m_pc      = m_pc + 32'd4;
        m_fetched = sat_inc(m_fetched);
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_pc, e_instr;
    e_pc    = (q.size() > 0) ? q[0].pc : 32'h0;
    e_instr = (q.size() > 0) ? q[0].instr : 32'h0;
    check("pc",        pc, m_pc);
    check("out_valid", 32'(dbus.out_valid), 32'(q.size() > 0));
    check("out_pc",    dbus.out_pc, e_pc);
    check("out_instr", dbus.out_instr, e_instr);
    check("busy",      32'(busy), 32'((mode == 1) || (q.size() > 0)));
    check("halted",    32'(halted), 32'((mode == 2) && (q.size() == 0)));
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_stalls",  perf_stalls, m_stalls);
`endif
  endtask

  // One transaction per clock: check the cycle's outputs, then drive the next inputs.
  task automatic step(input logic s, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    check_outputs();
    $display("cyc %0d: start=%0b redir=%0b rpc=%h rdy=%0b | pc=%h vld=%0b out_pc=%h busy=%0b halted=%0b",
             cyc, s, rv, rpc, rdy, pc, dbus.out_valid, dbus.out_pc, busy, halted);
    start          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dbus.out_ready = rdy;
    model_update(s, rv, rpc, rdy);
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) imem[i] = 32'hA000_0000 | (32'(i) << 2);
    dbus.out_ready = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("reset_instr", dbus.out_instr, 32'h0);
    rst_n = 1'b1;

    // Full stream to the end address, then halted after the last word drains
    step(1'b1, 1'b0, '0, 1'b1);
    repeat (40) step(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    check("stream_halted", 32'(halted), 32'd1);

    // Backpressure: buffer fills, PC holds, head stays put; then drain in order
    step(1'b1, 1'b0, '0, 1'b0);
    repeat (7) step(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("bp_pc_hold", pc, 32'h08);
    check("bp_head",    dbus.out_pc, 32'h00);
    repeat (6) step(1'b0, 1'b0, '0, 1'b1);

    // Redirect while the head is 0x0C, to an unaligned target
    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (q.size() > 0 && q[0].pc == 32'h0C) break;
      step(1'b0, 1'b0, '0, 1'b1);
    end
    step(1'b0, 1'b1, 32'h41, 1'b1);
    repeat (5) step(1'b0, 1'b0, '0, 1'b1);

    // Redirect + start + full buffer + ready in the same cycle
    repeat (4) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 32'h20, 1'b1);
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);

    // Redirect to the end address halts with nothing pushed; start resumes at 0
    step(1'b0, 1'b1, 32'h80, 1'b1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5,
           32'($urandom_range(0, 32'h9F)), $urandom_range(0, 99) < 70);
    end

    // Asynchronous reset with a full buffer
    step(1'b1, 1'b0, '0, 1'b0);
    repeat (5) step(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check_outputs();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", 32'(dbus.out_valid), 32'd0);
    check("arst_pc",    pc, RESET_PC);
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
